// File: rtl/mux_2x1_pkg.sv
// Shared types and constants for the mux_2x1 block: default widths, the select
// encoding and the select-toggle counter saturation value.
package mux_2x1_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

  // All-ones value for a counter of width w (w <= 64); the counter holds here.
  function automatic logic [63:0] cnt_sat(input int unsigned w);
    cnt_sat = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/mux2_comb.sv
// Purely combinational WIDTH-bit 2:1 select: y = sel ? b : a.
module mux2_comb #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux_2x1.sv
// 2:1 mux with a registered output copy and select-change statistics.
// Define MUX_2X1_STATS_EN to build the sel_chg pulse and sel_cnt counter.
module mux_2x1
  import mux_2x1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sl_1,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             sel_chg,
  output logic [CNT_W-1:0] sel_cnt
);

  logic [WIDTH-1:0] y_comb;
  logic [WIDTH-1:0] y_q_reg;
  sel_e             sel_q;
  logic             sel_diff;

  mux2_comb #(.WIDTH(WIDTH)) u_mux (
    .a   (a),
    .b   (b),
    .sel (sl_1),
    .y   (y_comb)
  );

  assign y   = y_comb;
  assign y_q = y_q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q_reg <= '0;
      sel_q   <= SEL_A;
    end else begin
      y_q_reg <= y_comb;
      sel_q   <= sel_e'(sl_1);
    end
  end

  assign sel_diff = (sel_e'(sl_1) != sel_q);

`ifdef MUX_2X1_STATS_EN
  localparam logic [63:0]      SAT_FULL = cnt_sat(CNT_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = SAT_FULL[CNT_W-1:0];

  logic             sel_chg_reg;
  logic [CNT_W-1:0] sel_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_chg_reg <= 1'b0;
      sel_cnt_reg <= '0;
    end else begin
      sel_chg_reg <= sel_diff;
      if (sel_diff && (sel_cnt_reg != CNT_SAT))
        sel_cnt_reg <= sel_cnt_reg + CNT_W'(1);
    end
  end

  assign sel_chg = sel_chg_reg;
  assign sel_cnt = sel_cnt_reg;
`else
  // sel_q is kept in this build too; the mask forces the pulse low.
  assign sel_chg = sel_diff & 1'b0;
  assign sel_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_2x1.sv
// Self-checking bench for mux_2x1: vector table, directed sequences and random
// traffic against a behavioural model; honours MUX_2X1_STATS_EN if defined.
module tb_mux_2x1;

`ifdef MUX_2X1_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int W8 = 8;
  localparam int C8 = 8;
  localparam int C2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Small instance: WIDTH=1, CNT_W=2 for exhaustive, stats and saturation tests
  logic          a1 = 1'b0, b1 = 1'b0, s1 = 1'b0;
  logic          y1, yq1, chg1;
  logic [C2-1:0] cnt1;
  // Wide instance: WIDTH=8, CNT_W=8 for random traffic
  logic [W8-1:0] a8 = '0, b8 = '0;
  logic          s8 = 1'b0;
  logic [W8-1:0] y8, yq8;
  logic          chg8;
  logic [C8-1:0] cnt8;

  mux_2x1 #(.WIDTH(1), .CNT_W(C2)) dut_s (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .sl_1(s1),
    .y(y1), .y_q(yq1), .sel_chg(chg1), .sel_cnt(cnt1)
  );

  mux_2x1 #(.WIDTH(W8), .CNT_W(C8)) dut (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .sl_1(s8),
    .y(y8), .y_q(yq8), .sel_chg(chg8), .sel_cnt(cnt8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", nm, act, $time);
    end
  endtask

  typedef struct {
    logic s, a, b, y;
  } vec_t;

  // Apply one sample to the small instance, then observe just after the edge
  task automatic step1(input logic s, input logic a, input logic b);
    @(negedge clk);
    s1 = s; a1 = a; b1 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("rst_yq1", yq1, 0);
    check("rst_chg1", chg1, 0);
    check("rst_cnt1", cnt1, 0);
    check("rst_yq8", yq8, 0);
    check("rst_cnt8", cnt8, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[8];
  int   exp_chg[5];
  int   exp_cnt[5];
  int   seq[5];

  initial begin
    // Exhaustive combinational sweep, order (sl_1,a,b) = 000..111
    for (int i = 0; i < 8; i++) begin
      vecs[i].s = i[2];
      vecs[i].a = i[1];
      vecs[i].b = i[0];
    end
    vecs[0].y = 0; vecs[1].y = 0; vecs[2].y = 1; vecs[3].y = 1;
    vecs[4].y = 0; vecs[5].y = 1; vecs[6].y = 0; vecs[7].y = 1;

    #3;
    for (int i = 0; i < 8; i++) begin
      s1 = vecs[i].s; a1 = vecs[i].a; b1 = vecs[i].b;
      #10;
      check($sformatf("comb_%0d%0d%0d", vecs[i].s, vecs[i].a, vecs[i].b), y1, vecs[i].y);
    end

    do_reset();

    // Registered path
    step1(1'b1, 1'b0, 1'b1);
    check("regpath_yq_b", yq1, 1);
    step1(1'b0, 1'b0, 1'b1);
    check("regpath_yq_a", yq1, 0);

    // Select statistics: sl_1 = 0,1,1,0,1 from reset
    do_reset();
    seq = '{0, 1, 1, 0, 1};
    exp_chg = '{0, 1, 0, 1, 1};
    exp_cnt = '{0, 1, 1, 2, 3};
    for (int i = 0; i < 5; i++) begin
      step1(seq[i][0], 1'b0, 1'b1);
      check($sformatf("stats_chg_e%0d", i + 1), chg1, STATS ? exp_chg[i] : 0);
      check($sformatf("stats_cnt_e%0d", i + 1), cnt1, STATS ? exp_cnt[i] : 0);
      check($sformatf("stats_yq_e%0d", i + 1), yq1, seq[i]);
    end

    // Saturation with CNT_W=2: toggle every edge for 6 edges
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step1(((i % 2) == 0), 1'b0, 1'b0);
      check($sformatf("sat_cnt_e%0d", i + 1), cnt1, STATS ? ((i + 1 > 3) ? 3 : i + 1) : 0);
    end

    // Async reset mid-run with sel_cnt=2 and y_q=1
    do_reset();
    step1(1'b1, 1'b1, 1'b0);
    step1(1'b0, 1'b1, 1'b0);
    check("midrst_pre_cnt", cnt1, STATS ? 2 : 0);
    check("midrst_pre_yq", yq1, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_cnt", cnt1, 0);
    check("midrst_yq", yq1, 0);
    check("midrst_chg", chg1, 0);
    check("midrst_y", y1, 1);
    b1 = 1'b0; a1 = 1'b0;
    #1;
    check("midrst_y_track", y1, 0);
    @(negedge clk);
    rst = 1'b0;

    // First edge after release: a sample of 1 pulses sel_chg
    step1(1'b1, 1'b0, 1'b1);
    check("first_edge_chg", chg1, STATS ? 1 : 0);

    // Random traffic on the wide instance against a behavioural model
    begin
      int          prev_m;
      int          cnt_m;
      int          chg_m;
      int          max_m;
      logic [W8-1:0] yq_m;
      logic [W8-1:0] y_m;
      do_reset();
      prev_m = 0; cnt_m = 0; chg_m = 0; yq_m = '0;
      max_m = (1 << C8) - 1;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        a8 = W8'($urandom);
        b8 = W8'($urandom);
        s8 = ($urandom_range(0, 3) == 0) ? ~s8 : s8;
        #1;
        y_m = s8 ? b8 : a8;
        check("rnd_y", y8, y_m);
        @(posedge clk);
        chg_m  = (int'(s8) != prev_m) ? 1 : 0;
        prev_m = int'(s8);
        if (chg_m == 1) cnt_m = (cnt_m + 1 > max_m) ? max_m : cnt_m + 1;
        yq_m = y_m;
        #1;
        if ((i % 10) == 9 || chg_m == 1) begin
          check("rnd_yq", yq8, yq_m);
          check("rnd_chg", chg8, STATS ? chg_m : 0);
          check("rnd_cnt", cnt8, STATS ? cnt_m : 0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
